// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC pipeline output stage.
// Data is sign-magnitude Q7.8: bit 15 is the sign, the rest is magnitude.
package cordic_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned FRAC   = 8;
    localparam int unsigned K_COEF = 155;
    localparam int unsigned K_BITS = 8;

    localparam logic MODE_ROTATE = 1'b0;
    localparam logic MODE_PHASE  = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/sm_shift_add_mul.sv
// Serial unsigned magnitude x constant multiplier, one coefficient bit per cycle (LSB first).
// The result is the product rounded half-up and scaled down by 2^K_BITS.
module sm_shift_add_mul #(
    parameter int unsigned MAG_W  = 15,
    parameter int unsigned K_BITS = 8,
    parameter int unsigned K_COEF = 155
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [MAG_W-1:0] mag,
    output logic             busy,
    output logic             done,
    output logic [MAG_W-1:0] result
);

    localparam int unsigned ACC_W = MAG_W + K_BITS;
    localparam int unsigned CNT_W = (K_BITS > 1) ? $clog2(K_BITS) : 1;
    localparam logic [K_BITS-1:0] COEF = K_BITS'(K_COEF);
    localparam logic [ACC_W-1:0]  HALF = ACC_W'(1) << (K_BITS - 1);

    logic [MAG_W-1:0] mag_q, mag_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mag_q  <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mag_q  <= mag_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        mag_d  = mag_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            mag_d  = mag;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (COEF[cnt_q]) begin
                acc_d = acc_q + ({{K_BITS{1'b0}}, mag_q} << cnt_q);
            end
            if (cnt_q == CNT_W'(K_BITS - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // (2^MAG_W - 1) * (2^K_BITS - 1) + 2^(K_BITS-1) still fits in ACC_W bits.
    assign result = MAG_W'((acc_q + HALF) >> K_BITS);
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: rtl/cordic_gain_comp.sv
// Gain-compensation output stage behind the last CORDIC stage: scales magnitudes by
// K_COEF / 2^K_BITS, normalises negative zero and presents results on a valid/ready handshake.
module cordic_gain_comp #(
    parameter int unsigned WIDTH  = cordic_pkg::WIDTH,
    parameter int unsigned FRAC   = cordic_pkg::FRAC,
    parameter int unsigned K_COEF = cordic_pkg::K_COEF,
    parameter int unsigned K_BITS = cordic_pkg::K_BITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic             mode,
    input  logic             drop_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             mode_out,
    output logic             drop
);

    import cordic_pkg::*;

    localparam int unsigned MAG_W = WIDTH - 1;

    if (FRAC >= MAG_W) begin : g_bad_frac
        $error("FRAC must leave at least one integer bit");
    end
    if (K_COEF >= (1 << K_BITS)) begin : g_bad_coef
        $error("K_COEF must be below 2^K_BITS");
    end

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic             x_sign_q, x_sign_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0] x_out_q, x_out_d;
    logic [WIDTH-1:0] y_out_q, y_out_d;
    logic [WIDTH-1:0] z_out_q, z_out_d;
    logic             mode_out_q, mode_out_d;
    logic             drop_q, drop_d;

    logic             accept;
    logic             start_y;
    logic             x_busy, y_busy;
    logic             x_done, y_done;
    logic             mul_finish;
    logic [MAG_W-1:0] x_res, y_res;

    sm_shift_add_mul #(
        .MAG_W (MAG_W),
        .K_BITS(K_BITS),
        .K_COEF(K_COEF)
    ) u_mul_x (
        .clock (clock),
        .reset (reset),
        .start (accept),
        .mag   (x[MAG_W-1:0]),
        .busy  (x_busy),
        .done  (x_done),
        .result(x_res)
    );

    // Never started in phase_calc mode: y passes through untouched.
    sm_shift_add_mul #(
        .MAG_W (MAG_W),
        .K_BITS(K_BITS),
        .K_COEF(K_COEF)
    ) u_mul_y (
        .clock (clock),
        .reset (reset),
        .start (start_y),
        .mag   (y[MAG_W-1:0]),
        .busy  (y_busy),
        .done  (y_done),
        .result(y_res)
    );

    assign mul_finish = x_done & (y_done | (mode_q == MODE_PHASE)) & ~(x_busy | y_busy);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid)   state_d = StMul;
            StMul:  if (mul_finish) state_d = StDone;
            StDone: if (out_ready)  state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    // Handshake outputs decode registered state only; out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        accept    = in_ready & in_valid;
        start_y   = accept & (mode == MODE_ROTATE);
    end

    always_comb begin
        mode_d     = mode_q;
        x_sign_d   = x_sign_q;
        y_d        = y_q;
        z_d        = z_q;
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;
        z_out_d    = z_out_q;
        mode_out_d = mode_out_q;
        drop_d     = drop_q;

        if (accept) begin
            mode_d   = mode;
            x_sign_d = x[WIDTH-1];
            y_d      = y;
            z_d      = z;
        end

        // A zero magnitude always leaves with a positive sign.
        if ((state_q == StMul) && mul_finish) begin
            x_out_d = {x_sign_q & (|x_res), x_res};
            if (mode_q == MODE_ROTATE) begin
                y_out_d = {y_q[WIDTH-1] & (|y_res), y_res};
            end else begin
                y_out_d = {y_q[WIDTH-1] & (|y_q[MAG_W-1:0]), y_q[MAG_W-1:0]};
            end
            z_out_d    = {z_q[WIDTH-1] & (|z_q[MAG_W-1:0]), z_q[MAG_W-1:0]};
            mode_out_d = mode_q;
        end

        if (in_valid && !in_ready) begin
            drop_d = 1'b1;
        end else if (drop_clr) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q     <= 1'b0;
            x_sign_q   <= 1'b0;
            y_q        <= '0;
            z_q        <= '0;
            x_out_q    <= '0;
            y_out_q    <= '0;
            z_out_q    <= '0;
            mode_out_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            x_sign_q   <= x_sign_d;
            y_q        <= y_d;
            z_q        <= z_d;
            x_out_q    <= x_out_d;
            y_out_q    <= y_out_d;
            z_out_q    <= z_out_d;
            mode_out_q <= mode_out_d;
            drop_q     <= drop_d;
        end
    end

    assign x_out    = x_out_q;
    assign y_out    = y_out_q;
    assign z_out    = z_out_q;
    assign mode_out = mode_out_q;
    assign drop     = drop_q;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Self-checking bench for cordic_gain_comp: directed vectors, randomized traffic against
// an arithmetic reference model, backpressure/drop behaviour and reset during a multiply.
module tb_cordic_gain_comp;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        mode = 1'b0;
    logic        drop_clr = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] x = '0, y = '0, z = '0;
    logic        in_ready, out_valid, mode_out, drop;
    logic [15:0] x_out, y_out, z_out;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    cordic_gain_comp dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .z        (z),
        .mode     (mode),
        .drop_clr (drop_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out    (x_out),
        .y_out    (y_out),
        .z_out    (z_out),
        .mode_out (mode_out),
        .drop     (drop)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Reference: magnitude * 155/256, rounded half up, zero magnitude forced positive.
    function automatic logic [15:0] model_scale(input logic [15:0] v);
        int unsigned m;
        m = v[14:0];
        m = (m * 155 + 128) / 256;
        return {v[15] && (m != 0), m[14:0]};
    endfunction

    function automatic logic [15:0] model_pass(input logic [15:0] v);
        return {v[15] && (v[14:0] != 0), v[14:0]};
    endfunction

    // Drives one input beat; returns with the accept edge behind us, at the next negedge.
    task automatic send(input logic [15:0] xi, yi, zi, input logic mi, output logic rdy);
        @(negedge clock);
        rdy = in_ready;
        x = xi; y = yi; z = zi; mode = mi;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Counts clock cycles from the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(negedge clock);
            lat++;
            if (out_valid === 1'b1) break;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks += 6;
        if (x_out !== 16'h0) begin failures++; $display("FAIL reset_x_out: got %h want 0000", x_out); end
        if (y_out !== 16'h0) begin failures++; $display("FAIL reset_y_out: got %h want 0000", y_out); end
        if (z_out !== 16'h0) begin failures++; $display("FAIL reset_z_out: got %h want 0000", z_out); end
        if (mode_out !== 1'b0) begin failures++; $display("FAIL reset_mode_out: got %b want 0", mode_out); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop: got %b want 0", drop); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    logic [15:0] dv_x [6] = '{16'h0100, 16'h8200, 16'h0A00, 16'h0001, 16'h8000, 16'h7FFF};
    logic [15:0] dv_y [6] = '{16'h0000, 16'h8100, 16'h8003, 16'h0000, 16'h8000, 16'h0000};
    logic [15:0] dv_z [6] = '{16'h0012, 16'h0000, 16'h00C9, 16'h0000, 16'h8000, 16'h0000};
    logic        dv_m [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] ex_x [6] = '{16'h009B, 16'h8136, 16'h060E, 16'h0001, 16'h0000, 16'h4D7F};
    logic [15:0] ex_y [6] = '{16'h0000, 16'h809B, 16'h8003, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] ex_z [6] = '{16'h0012, 16'h0000, 16'h00C9, 16'h0000, 16'h0000, 16'h0000};

    task automatic test_directed();
        logic rdy;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            send(dv_x[i], dv_y[i], dv_z[i], dv_m[i], rdy);
            wait_valid(lat);
            checks += 6;
            if (rdy !== 1'b1) begin failures++; $display("FAIL dir%0d_in_ready: got %b want 1", i, rdy); end
            if (lat != 9) begin failures++; $display("FAIL dir%0d_latency: got %0d want 9", i, lat); end
            if (x_out !== ex_x[i]) begin failures++; $display("FAIL dir%0d_x_out: got %h want %h", i, x_out, ex_x[i]); end
            if (y_out !== ex_y[i]) begin failures++; $display("FAIL dir%0d_y_out: got %h want %h", i, y_out, ex_y[i]); end
            if (z_out !== ex_z[i]) begin failures++; $display("FAIL dir%0d_z_out: got %h want %h", i, z_out, ex_z[i]); end
            if (mode_out !== dv_m[i]) begin failures++; $display("FAIL dir%0d_mode_out: got %b want %b", i, mode_out, dv_m[i]); end
            handshake();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_valid_drop: got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_random();
        logic [15:0] xi, yi, zi, ex, ey, ez;
        logic        mi, rdy;
        int          lat, hold;
        for (int i = 0; i < 40; i++) begin
            xi = 16'($urandom); yi = 16'($urandom); zi = 16'($urandom);
            if ($urandom_range(3) == 0) xi[14:0] = '0;
            if ($urandom_range(3) == 0) yi[14:0] = '0;
            if ($urandom_range(3) == 0) zi[14:0] = '0;
            mi = 1'($urandom_range(1));
            ex = model_scale(xi);
            ey = (mi == 1'b0) ? model_scale(yi) : model_pass(yi);
            ez = model_pass(zi);
            send(xi, yi, zi, mi, rdy);
            wait_valid(lat);
            hold = $urandom_range(3);
            repeat (hold) @(negedge clock);
            checks += 7;
            if (rdy !== 1'b1) begin failures++; $display("FAIL rnd%0d_in_ready: got %b want 1", i, rdy); end
            if (lat != 9) begin failures++; $display("FAIL rnd%0d_latency: got %0d want 9", i, lat); end
            if (out_valid !== 1'b1) begin failures++; $display("FAIL rnd%0d_valid_held: got %b want 1", i, out_valid); end
            if (x_out !== ex) begin failures++; $display("FAIL rnd%0d_x_out (in %h): got %h want %h", i, xi, x_out, ex); end
            if (y_out !== ey) begin failures++; $display("FAIL rnd%0d_y_out (in %h m%b): got %h want %h", i, yi, mi, y_out, ey); end
            if (z_out !== ez) begin failures++; $display("FAIL rnd%0d_z_out (in %h): got %h want %h", i, zi, z_out, ez); end
            if (mode_out !== mi) begin failures++; $display("FAIL rnd%0d_mode_out: got %b want %b", i, mode_out, mi); end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ex, ey, ez;
        logic        rdy, seen;
        int          lat;
        ex = model_scale(16'h1234); ey = model_scale(16'h8456); ez = model_pass(16'h8000);
        send(16'h1234, 16'h8456, 16'h8000, 1'b0, rdy);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clock);
            checks += 5;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp%0d_out_valid: got %b want 1", c, out_valid); end
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp%0d_in_ready: got %b want 0", c, in_ready); end
            if (x_out !== ex) begin failures++; $display("FAIL bp%0d_x_out: got %h want %h", c, x_out, ex); end
            if (y_out !== ey) begin failures++; $display("FAIL bp%0d_y_out: got %h want %h", c, y_out, ey); end
            if (z_out !== ez) begin failures++; $display("FAIL bp%0d_z_out: got %h want %h", c, z_out, ez); end
            if (c == 1) begin x = 16'h0700; y = 16'h0300; in_valid = 1'b1; end
            if (c == 2) in_valid = 1'b0;
        end
        checks++;
        if (drop !== 1'b1) begin failures++; $display("FAIL bp_drop_set: got %b want 1", drop); end
        handshake();
        seen = 1'b0;
        repeat (14) begin
            @(negedge clock);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks += 2;
        if (seen !== 1'b0) begin failures++; $display("FAIL bp_dropped_sample_emitted: got %b want 0", seen); end
        if (drop !== 1'b1) begin failures++; $display("FAIL bp_drop_sticky: got %b want 1", drop); end
        drop_clr = 1'b1;
        @(negedge clock);
        drop_clr = 1'b0;
        checks++;
        if (drop !== 1'b0) begin failures++; $display("FAIL bp_drop_clr: got %b want 0", drop); end

        // Set and clear in the same cycle: set wins.
        ex = model_scale(16'h0321);
        send(16'h0321, 16'h0000, 16'h0000, 1'b1, rdy);
        x = 16'h0111; in_valid = 1'b1; drop_clr = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; drop_clr = 1'b0;
        checks++;
        if (drop !== 1'b1) begin failures++; $display("FAIL bp_set_wins: got %b want 1", drop); end
        wait_valid(lat);
        checks++;
        if (x_out !== ex) begin failures++; $display("FAIL bp_after_drop_x_out: got %h want %h", x_out, ex); end
        handshake();
        drop_clr = 1'b1;
        @(negedge clock);
        drop_clr = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic rdy, seen;
        int   lat;
        send(16'h0300, 16'h0200, 16'h0055, 1'b0, rdy);
        wait_valid(lat);
        handshake();
        send(16'h0100, 16'h0000, 16'h0012, 1'b0, rdy);
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
        #1;
        checks += 6;
        if (x_out !== 16'h0) begin failures++; $display("FAIL mr_x_out: got %h want 0000", x_out); end
        if (y_out !== 16'h0) begin failures++; $display("FAIL mr_y_out: got %h want 0000", y_out); end
        if (z_out !== 16'h0) begin failures++; $display("FAIL mr_z_out: got %h want 0000", z_out); end
        if (mode_out !== 1'b0) begin failures++; $display("FAIL mr_mode_out: got %b want 0", mode_out); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mr_out_valid: got %b want 0", out_valid); end
        if (drop !== 1'b0) begin failures++; $display("FAIL mr_drop: got %b want 0", drop); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL mr_in_ready: got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (14) begin
            @(negedge clock);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL mr_abandoned_emitted: got %b want 0", seen); end
        send(16'h0100, 16'h0000, 16'h0012, 1'b0, rdy);
        wait_valid(lat);
        checks += 4;
        if (lat != 9) begin failures++; $display("FAIL mr_next_latency: got %0d want 9", lat); end
        if (x_out !== 16'h009B) begin failures++; $display("FAIL mr_next_x_out: got %h want 009b", x_out); end
        if (y_out !== 16'h0000) begin failures++; $display("FAIL mr_next_y_out: got %h want 0000", y_out); end
        if (z_out !== 16'h0012) begin failures++; $display("FAIL mr_next_z_out: got %h want 0012", z_out); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
